ram_dp_be: RTL and testbench

- Next-generation on-chip data RAM for the MIPS v2 datapath.
- Port A: read/write with byte enables. Port B: read-only, for debug/DMA or a second load path.
- Adds configurable read latency, same-address collision policy, out-of-range detection, and per-port valid/err responses.
- Keeps the existing rules: write has priority over read on a port, and read data holds between reads.

---
 rtl/ram_pkg.sv | 31 +++
 rtl/ram_rd_pipe.sv | 75 +++++++
 rtl/ram_dp_be.sv | 144 ++++++++++++++
 tb/tb_ram_dp_be.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port byte-enable data RAM: collision policy
// encodings, byte-count helper and the byte-lane merge used by writes and bypass.
package ram_pkg;

    localparam int COLL_WRITE_FIRST = 0;
    localparam int COLL_READ_FIRST  = 1;

    // Widest word the generic merge supports; narrower words are zero-extended in.
    localparam int MERGE_MAX_W = 1024;
    localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

    function automatic int byte_count(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [MERGE_MAX_W-1:0] merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_B-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_word;
        for (int k = 0; k < MERGE_MAX_B; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Per-port read response pipeline carrying {valid, err, data}; READ_LATENCY is 1
// (output register only) or 2 (one extra stage). Output data holds between reads.
module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_err,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_data
);

    logic                  stage_vld;
    logic                  stage_err;
    logic [DATA_WIDTH-1:0] stage_data;

    logic                  vld_p1;
    logic                  err_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  vld_p0;
            logic                  err_p0;
            logic [DATA_WIDTH-1:0] data_p0;

            // Stage p0: extra register inserted ahead of the output register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p0  <= 1'b0;
                    err_p0  <= 1'b0;
                    data_p0 <= '0;
                end else begin
                    vld_p0  <= req_valid;
                    err_p0  <= req_err;
                    data_p0 <= req_data;
                end
            end

            assign stage_vld  = vld_p0;
            assign stage_err  = err_p0;
            assign stage_data = data_p0;
        end else begin : g_lat1
            assign stage_vld  = req_valid;
            assign stage_err  = req_err;
            assign stage_data = req_data;
        end
    endgenerate

    // Stage p1: output register; data only moves when a read completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= stage_vld;
            err_p1 <= stage_err;
            if (stage_vld) begin
                data_p1 <= stage_data;
            end
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_err   = err_p1;
    assign rsp_data  = data_p1;

endmodule

// File: rtl/ram_dp_be.sv
// Dual-port data RAM: port A read/write with byte enables, port B read-only,
// with range checking, configurable read latency and A-write/B-read collision policy.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int CELLS          = 256,
    parameter int READ_LATENCY   = 1,
    parameter int COLLISION_MODE = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_a_we,
    input  logic                    i_a_oe,
    input  logic [DATA_WIDTH/8-1:0] i_a_be,
    input  logic [ADDR_WIDTH-1:0]   i_a_addr,
    input  logic [DATA_WIDTH-1:0]   i_a_data,
    output logic [DATA_WIDTH-1:0]   o_a_data,
    output logic                    o_a_valid,
    output logic                    o_a_err,
    input  logic                    i_b_oe,
    input  logic [ADDR_WIDTH-1:0]   i_b_addr,
    output logic [DATA_WIDTH-1:0]   o_b_data,
    output logic                    o_b_valid,
    output logic                    o_b_err
);

    localparam int BYTES = byte_count(DATA_WIDTH);
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [ADDR_WIDTH:0] CELLS_L = (ADDR_WIDTH+1)'(CELLS);

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > MERGE_MAX_W) begin : g_bad_width
            $error("ram_dp_be: DATA_WIDTH must be a non-zero multiple of 8 up to MERGE_MAX_W");
        end
        if (CELLS < 1 || longint'(CELLS) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_cells
            $error("ram_dp_be: CELLS must be in 1..2**ADDR_WIDTH");
        end
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("ram_dp_be: READ_LATENCY must be 1 or 2");
        end
        if (COLLISION_MODE != COLL_WRITE_FIRST && COLLISION_MODE != COLL_READ_FIRST) begin : g_bad_coll
            $error("ram_dp_be: COLLISION_MODE must be 0 or 1");
        end
    endgenerate

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BYTES-1:0]      be
    );
        logic [MERGE_MAX_W-1:0] wide;
        wide = merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word), MERGE_MAX_B'(be));
        return wide[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [CELLS];

    logic                  a_in_range;
    logic                  b_in_range;
    logic [IDX_W-1:0]      a_idx;
    logic [IDX_W-1:0]      b_idx;
    logic [DATA_WIDTH-1:0] a_word;
    logic [DATA_WIDTH-1:0] b_word;
    logic [DATA_WIDTH-1:0] a_merged;
    logic                  a_wr_en;
    logic                  a_rd;
    logic                  b_collide;
    logic                  a_req_err;
    logic                  b_req_err;
    logic [DATA_WIDTH-1:0] a_rd_data;
    logic [DATA_WIDTH-1:0] b_rd_data;

    assign a_in_range = ({1'b0, i_a_addr} < CELLS_L);
    assign b_in_range = ({1'b0, i_b_addr} < CELLS_L);
    assign a_idx      = i_a_addr[IDX_W-1:0];
    assign b_idx      = i_b_addr[IDX_W-1:0];
    assign a_word     = mem[a_idx];
    assign b_word     = mem[b_idx];
    assign a_merged   = merge_word(a_word, i_a_data, i_a_be);

    // A write wins over an A read; nothing is written while reset is held
    assign a_wr_en   = i_rst_n && i_a_we && a_in_range;
    assign a_rd      = i_a_oe && !i_a_we;
    assign b_collide = a_wr_en && (i_a_addr == i_b_addr);

    assign a_req_err = (i_a_we || i_a_oe) && !a_in_range;
    assign b_req_err = i_b_oe && !b_in_range;

    always_comb begin
        a_rd_data = '0;
        if (a_in_range) begin
            a_rd_data = a_word;
        end
    end

    // WRITE_FIRST forwards the merged word so B sees A's bytes on the same edge
    always_comb begin
        b_rd_data = '0;
        if (b_in_range) begin
            if (b_collide && COLLISION_MODE == COLL_WRITE_FIRST) begin
                b_rd_data = a_merged;
            end else begin
                b_rd_data = b_word;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (a_wr_en) begin
            mem[a_idx] <= a_merged;
        end
    end

    ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe_a (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .req_valid (a_rd),
        .req_err   (a_req_err),
        .req_data  (a_rd_data),
        .rsp_valid (o_a_valid),
        .rsp_err   (o_a_err),
        .rsp_data  (o_a_data)
    );

    ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe_b (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .req_valid (i_b_oe),
        .req_err   (b_req_err),
        .req_data  (b_rd_data),
        .rsp_valid (o_b_valid),
        .rsp_err   (o_b_err),
        .rsp_data  (o_b_data)
    );

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench: two instances share stimulus; u_wf is CELLS=200/latency 1/WRITE_FIRST,
// u_rf is CELLS=256/latency 2/READ_FIRST.
module tb_ram_dp_be;

    logic        clk;
    logic        rst_n;
    logic        a_we;
    logic        a_oe;
    logic [3:0]  a_be;
    logic [7:0]  a_addr;
    logic [31:0] a_data;
    logic        b_oe;
    logic [7:0]  b_addr;

    logic [31:0] a0_data, b0_data, a1_data, b1_data;
    logic        a0_valid, a0_err, b0_valid, b0_err;
    logic        a1_valid, a1_err, b1_valid, b1_err;

    int checks = 0;
    int errors = 0;

    ram_dp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .CELLS(200), .READ_LATENCY(1), .COLLISION_MODE(0)
    ) u_wf (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_we(a_we), .i_a_oe(a_oe), .i_a_be(a_be), .i_a_addr(a_addr), .i_a_data(a_data),
        .o_a_data(a0_data), .o_a_valid(a0_valid), .o_a_err(a0_err),
        .i_b_oe(b_oe), .i_b_addr(b_addr),
        .o_b_data(b0_data), .o_b_valid(b0_valid), .o_b_err(b0_err)
    );

    ram_dp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .CELLS(256), .READ_LATENCY(2), .COLLISION_MODE(1)
    ) u_rf (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_we(a_we), .i_a_oe(a_oe), .i_a_be(a_be), .i_a_addr(a_addr), .i_a_data(a_data),
        .o_a_data(a1_data), .o_a_valid(a1_valid), .o_a_err(a1_err),
        .i_b_oe(b_oe), .i_b_addr(b_addr),
        .o_b_data(b1_data), .o_b_valid(b1_valid), .o_b_err(b1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we = 1'b0; a_oe = 1'b0; a_be = 4'h0; a_addr = 8'h0; a_data = 32'h0;
        b_oe = 1'b0; b_addr = 8'h0;
    endtask

    task automatic wr_a(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        idle();
        a_we = 1'b1; a_addr = addr; a_data = data; a_be = be;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_a0_data",  a0_data, 32'h0);
        chk("rst_a0_valid", 32'(a0_valid), 32'h0);
        chk("rst_a0_err",   32'(a0_err), 32'h0);
        chk("rst_b0_data",  b0_data, 32'h0);
        chk("rst_b1_valid", 32'(b1_valid), 32'h0);
        chk("rst_b1_err",   32'(b1_err), 32'h0);
        rst_n = 1'b1;
        step();

        // basic write then port B read, latency 1 vs 2
        wr_a(8'd5, 32'hDEADBEEF, 4'hF);
        chk("wr_no_valid", 32'(a0_valid), 32'h0);
        b_oe = 1'b1; b_addr = 8'd5;
        step();
        idle();
        chk("b0_rd5_data",  b0_data, 32'hDEADBEEF);
        chk("b0_rd5_valid", 32'(b0_valid), 32'h1);
        chk("b1_rd5_early", 32'(b1_valid), 32'h0);
        step();
        chk("b0_rd5_pulse", 32'(b0_valid), 32'h0);
        chk("b1_rd5_valid", 32'(b1_valid), 32'h1);
        chk("b1_rd5_data",  b1_data, 32'hDEADBEEF);
        step();
        chk("b1_rd5_pulse", 32'(b1_valid), 32'h0);
        chk("b0_hold",      b0_data, 32'hDEADBEEF);

        // byte enables
        wr_a(8'd3, 32'h11223344, 4'hF);
        wr_a(8'd3, 32'hAABBCCDD, 4'b0101);
        a_oe = 1'b1; a_addr = 8'd3;
        step();
        idle();
        chk("a0_be_data",  a0_data, 32'h11BB33DD);
        chk("a0_be_valid", 32'(a0_valid), 32'h1);
        step();
        chk("a1_be_data",  a1_data, 32'h11BB33DD);
        wr_a(8'd3, 32'hFFFFFFFF, 4'h0);
        a_oe = 1'b1; a_addr = 8'd3; b_oe = 1'b1; b_addr = 8'd3;
        step();
        idle();
        chk("a0_be0_data", a0_data, 32'h11BB33DD);
        chk("b0_same_addr", b0_data, 32'h11BB33DD);
        step();
        chk("a1_be0_data", a1_data, 32'h11BB33DD);
        chk("b1_same_addr", b1_data, 32'h11BB33DD);

        // collision: A writes addr 7 while B reads addr 7
        wr_a(8'd7, 32'h00000000, 4'hF);
        a_we = 1'b1; a_addr = 8'd7; a_data = 32'hFFFFFFFF; a_be = 4'b0011;
        b_oe = 1'b1; b_addr = 8'd7;
        step();
        idle();
        chk("coll_wf_data",  b0_data, 32'h0000FFFF);
        chk("coll_wf_valid", 32'(b0_valid), 32'h1);
        step();
        chk("coll_rf_data",  b1_data, 32'h00000000);
        chk("coll_rf_valid", 32'(b1_valid), 32'h1);
        b_oe = 1'b1; b_addr = 8'd7;
        step();
        idle();
        chk("coll_wf_after", b0_data, 32'h0000FFFF);
        step();
        chk("coll_rf_after", b1_data, 32'h0000FFFF);

        // out of range on the CELLS=200 instance
        a_oe = 1'b1; a_addr = 8'd250;
        step();
        idle();
        chk("oor_rd_data",  a0_data, 32'h0);
        chk("oor_rd_valid", 32'(a0_valid), 32'h1);
        chk("oor_rd_err",   32'(a0_err), 32'h1);
        step();
        chk("oor_rd_pulse", 32'(a0_err), 32'h0);
        chk("rf_250_noerr", 32'(a1_err), 32'h0);
        wr_a(8'd250, 32'h55555555, 4'hF);
        chk("oor_wr_err",   32'(a0_err), 32'h1);
        chk("oor_wr_valid", 32'(a0_valid), 32'h0);
        b_oe = 1'b1; b_addr = 8'd250;
        step();
        idle();
        chk("oor_b_err",  32'(b0_err), 32'h1);
        chk("oor_b_data", b0_data, 32'h0);
        wr_a(8'd199, 32'h12345678, 4'hF);
        chk("last_wr_err", 32'(a0_err), 32'h0);
        a_oe = 1'b1; a_addr = 8'd199;
        step();
        idle();
        chk("last_rd_data", a0_data, 32'h12345678);
        chk("last_rd_err",  32'(a0_err), 32'h0);

        // latency-2 streaming on port B
        for (int i = 0; i < 4; i++) wr_a(8'(i), 32'hA0 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) begin
            b_oe = 1'b1; b_addr = 8'(i);
            step();
            if (i == 0) chk("strm_first_idle", 32'(b1_valid), 32'h0);
            else begin
                chk("strm_valid", 32'(b1_valid), 32'h1);
                chk("strm_data",  b1_data, 32'hA0 + 32'(i - 1));
            end
        end
        idle();
        step();
        chk("strm_last_valid", 32'(b1_valid), 32'h1);
        chk("strm_last_data",  b1_data, 32'hA3);
        step();
        chk("strm_end_valid", 32'(b1_valid), 32'h0);
        chk("strm_hold",      b1_data, 32'hA3);

        // reset between accept and response
        b_oe = 1'b1; b_addr = 8'd5;
        step();
        idle();
        rst_n = 1'b0;
        #1;
        chk("mrst_b1_valid", 32'(b1_valid), 32'h0);
        chk("mrst_b1_data",  b1_data, 32'h0);
        chk("mrst_b0_data",  b0_data, 32'h0);
        a_we = 1'b1; a_addr = 8'd5; a_data = 32'h0; a_be = 4'hF;
        step();
        idle();
        chk("mrst_no_pulse", 32'(b1_valid), 32'h0);
        rst_n = 1'b1;
        step();
        chk("mrst_rel_valid", 32'(b1_valid), 32'h0);
        b_oe = 1'b1; b_addr = 8'd5;
        step();
        idle();
        chk("mrst_keep_b0", b0_data, 32'hDEADBEEF);
        step();
        chk("mrst_keep_b1", b1_data, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
